// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Definitions shared by the 1-to-7 demux scheduler and its round-robin finder:
// the FSM state encoding, the channel count and the "park" select code that
// leaves every demux output undriven.
// No ports (package).
// -----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam int         NUM_CH   = 7;
    localparam logic [2:0] SEL_PARK = 3'd7;

    // Channel index following g, wrapping 6 -> 0.
    function automatic logic [2:0] next_ch(input logic [2:0] g);
        return (g == 3'd6) ? 3'd0 : g + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick7.sv
// -----------------------------------------------------------------------------
// rr_pick7
// Combinational round-robin finder over seven channels. Returns the first
// enabled channel at or after ptr_i, wrapping 6 -> 0.
// Ports:
//   mask_i  [6:0] in   per-channel enable
//   ptr_i   [2:0] in   search start index (0..6)
//   grant_o [2:0] out  selected index (SEL_PARK when nothing is enabled)
//   any_o         out  at least one channel is enabled
// -----------------------------------------------------------------------------
module rr_pick7
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [2:0]        ptr_i,
    output logic [2:0]        grant_o,
    output logic              any_o
);

    always_comb begin
        grant_o = SEL_PARK;
        any_o   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            logic [3:0] sum;
            logic [2:0] idx;
            sum = {1'b0, ptr_i} + 4'(k);
            idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
            if (!any_o && mask_i[idx]) begin
                grant_o = idx;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux7_sched.sv
// -----------------------------------------------------------------------------
// demux7_sched
// Schedules single data bits from a source onto a downstream 1-to-7 demux.
// Each accepted bit is granted to the next enabled channel in round-robin
// order and held on Sel/D until that channel acknowledges, is disabled, or
// the wait exceeds TIMEOUT cycles (counted as a drop).
// Parameters: TIMEOUT (1..255) max SEND cycles, DROP_W drop counter width.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_data    source offers a data bit
//   in_ready      out   bit accepted this cycle
//   en_mask [6:0] in    per-channel enable
//   ch_ready[6:0] in    per-channel sink acknowledge
//   Sel     [2:0] out   demux select, 7 = park
//   D             out   demux data
//   done          out   one-cycle pulse on acknowledged transfer
//   drop_cnt      out   saturating count of aborted transfers
// -----------------------------------------------------------------------------
module demux7_sched
    import demux_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_data,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [2:0]        Sel,
    output logic              D,
    output logic              done,
    output logic [DROP_W-1:0] drop_cnt
);

    // wait_q holds (cycles spent in SEND) - 1, so the last allowed cycle
    // is the one where it equals TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        grant_q, grant_d;
    logic              data_q, data_d;
    logic [7:0]        wait_q, wait_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [2:0] pick;
    logic       pick_any;
    logic       ack;
    logic       abort;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

    rr_pick7 u_pick (
        .mask_i  (en_mask),
        .ptr_i   (ptr_q),
        .grant_o (pick),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        wait_d   = wait_q;
        drop_d   = drop_q;
        in_ready = 1'b0;
        Sel      = SEL_PARK;
        D        = 1'b0;
        done     = 1'b0;
        ack      = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Held low while rst is high so nothing is accepted in a reset cycle.
                in_ready = !rst && pick_any;
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    grant_d = pick;
                    wait_d  = 8'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                Sel    = grant_q;
                D      = data_q;
                ack    = ch_ready[grant_q];
                abort  = !en_mask[grant_q] || (wait_q == WAIT_LAST);
                wait_d = wait_q + 8'd1;
                // Ack takes priority over a simultaneous abort condition.
                if (ack) begin
                    done    = !rst;
                    ptr_d   = next_ch(grant_q);
                    state_d = ST_IDLE;
                end else if (abort) begin
                    drop_d  = sat_inc(drop_q);
                    ptr_d   = next_ch(grant_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            grant_q <= 3'd0;
            wait_q  <= 8'd0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wait_q  <= wait_d;
            drop_q  <= drop_d;
        end
    end

    // Data bit is only observed while in SEND, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux7_sched.sv
module tb_demux7_sched;

    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RESET = 2;

    typedef struct {
        int sel;
        int d;
    } start_t;

    typedef struct {
        int kind;
        int drop;
        int hold;
    } end_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       in_ready;
    logic [6:0] en_mask = 7'h7F;
    logic [6:0] ch_ready = 7'h00;
    logic [2:0] Sel;
    logic       D;
    logic       done;
    logic [2:0] drop_cnt;

    int tests = 0;
    int fails = 0;
    int exp_drop = 0;

    start_t start_q[$];
    end_t   end_q[$];

    bit mon_en   = 1'b0;
    bit in_send  = 1'b0;
    bit last_rst = 1'b0;
    int cur_sel  = 0;
    int cur_d    = 0;
    int hold     = 0;

    demux7_sched #(.TIMEOUT(15), .DROP_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .en_mask  (en_mask),
        .ch_ready (ch_ready),
        .Sel      (Sel),
        .D        (D),
        .done     (done),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one bit and record the expected start and end of its transfer.
    task automatic send(input bit d, input int g, input int kind, input int drop, input int hld);
        bit got;
        start_t s;
        end_t   e;
        s.sel = g; s.d = d;
        e.kind = kind; e.drop = drop; e.hold = hld;
        start_q.push_back(s);
        end_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready never rose, expected grant %0d", g);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_xfer(input int kind);
        end_t e;
        if (end_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_end: kind %0d, expected none", kind);
        end else begin
            e = end_q.pop_front();
            chk("end_kind", kind, e.kind);
            chk("end_drop_cnt", int'(drop_cnt), e.drop);
            if (e.hold != 0) chk("end_hold_cycles", hold, e.hold);
        end
        in_send = 1'b0;
    endtask

    // Monitor: detects transfer start (Sel leaves park), checks stability,
    // and classifies the end as done / abort / reset.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1 && Sel === 3'd7) begin
                tests++;
                fails++;
                $display("FAIL done_while_parked: done 1, expected 0");
            end
            if (!in_send) begin
                if (Sel !== 3'd7) begin
                    if (start_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_start: Sel %0d, expected 7", Sel);
                    end else begin
                        start_t s;
                        s = start_q.pop_front();
                        chk("start_sel", int'(Sel), s.sel);
                        chk("start_d", int'(D), s.d);
                    end
                    cur_sel = int'(Sel);
                    cur_d   = int'(D);
                    hold    = 1;
                    in_send = 1'b1;
                    if (done === 1'b1) finish_xfer(K_DONE);
                end
            end else begin
                if (Sel !== 3'd7) begin
                    hold++;
                    chk("send_sel_stable", int'(Sel), cur_sel);
                    chk("send_d_stable", int'(D), cur_d);
                    if (done === 1'b1) finish_xfer(K_DONE);
                end else begin
                    finish_xfer(last_rst ? K_RESET : K_ABORT);
                end
            end
            last_rst = rst;
        end
    end

    initial begin
        // Reset state, with channels enabled so in_ready gating is exercised.
        tick(3);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_sel", int'(Sel), 7);
        chk("rst_d", int'(D), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Four bits on all channels, all acked immediately.
        ch_ready = 7'h7F;
        send(1, 0, K_DONE, 0, 1);
        send(0, 1, K_DONE, 0, 1);
        send(1, 2, K_DONE, 0, 1);
        send(1, 3, K_DONE, 0, 1);
        tick(2);

        // Sparse mask from ptr=0: wrap skips disabled channels.
        rst = 1'b1; tick(1); rst = 1'b0;
        en_mask = 7'b0100100;
        send(1, 2, K_DONE, 0, 1);
        send(0, 5, K_DONE, 0, 1);
        send(1, 2, K_DONE, 0, 1);
        tick(2);

        // Timeout abort after exactly 15 SEND cycles.
        rst = 1'b1; tick(1); rst = 1'b0;
        en_mask = 7'h7F;
        ch_ready = 7'h00;
        exp_drop = 1;
        send(1, 0, K_ABORT, exp_drop, 15);
        tick(16);

        // Other channels' acks ignored; ack wins over simultaneous disable.
        ch_ready = 7'b1111101;
        send(0, 1, K_DONE, exp_drop, 3);
        tick(2);
        en_mask = 7'b1111101;
        ch_ready = 7'b0000010;
        tick(1);
        en_mask = 7'h7F;
        ch_ready = 7'h00;

        // Abort by disabling the granted channel.
        exp_drop = 2;
        send(1, 2, K_ABORT, exp_drop, 2);
        tick(1);
        en_mask = 7'b1111011;
        tick(1);
        en_mask = 7'h7F;
        tick(1);

        // No channel enabled: request is never accepted.
        en_mask = 7'h00;
        in_valid = 1'b1;
        in_data = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nomask_in_ready", int'(in_ready), 0);
            chk("nomask_sel", int'(Sel), 7);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        en_mask = 7'h7F;
        tick(1);

        // Repeated aborts drive drop_cnt into saturation; grants wrap 6 -> 0.
        for (int k = 0; k < 6; k++) begin
            exp_drop = (exp_drop < 7) ? exp_drop + 1 : 7;
            send(k[0], (3 + k) % 7, K_ABORT, exp_drop, 1);
            en_mask = 7'h00;
            tick(1);
            en_mask = 7'h7F;
        end
        tick(1);

        // Reset during SEND on channel 4, even with an ack present.
        en_mask = 7'b0010000;
        send(1, 4, K_RESET, 0, 2);
        tick(1);
        rst = 1'b1;
        ch_ready = 7'h7F;
        tick(1);
        rst = 1'b0;
        en_mask = 7'h7F;
        @(negedge clk);
        chk("post_rst_sel", int'(Sel), 7);
        chk("post_rst_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk);
        #1;
        exp_drop = 0;
        send(0, 0, K_DONE, 0, 1);
        tick(4);

        chk("start_queue_empty", start_q.size(), 0);
        chk("end_queue_empty", end_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung simulation.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

endmodule
